// File: rtl/ex_mem_stage.sv
// ex_mem_stage: EX/MEM pipeline register with 2-entry skid, branch resolution and overflow trap.
module ex_mem_stage #(
   parameter int DW = 32,
   parameter int RW = 5
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          ex_valid,
   output logic          ex_ready,
   input  logic [DW-1:0] alu_ri,
   input  logic          alu_co,
   input  logic          alu_zero,
   input  logic          alu_v,
   input  logic          alu_set,
   input  logic [DW-1:0] rt_data,
   input  logic [RW-1:0] rd_addr,
   input  logic          ctl_regwr,
   input  logic          ctl_memrd,
   input  logic          ctl_memwr,
   input  logic          ctl_branch,
   input  logic          ctl_bne,
   input  logic          ctl_trap,
   input  logic          flush,
   output logic          mem_valid,
   input  logic          mem_ready,
   output logic [DW-1:0] mem_result,
   output logic [3:0]    mem_flags,
   output logic [DW-1:0] mem_store,
   output logic [RW-1:0] mem_rd,
   output logic          mem_regwr,
   output logic          mem_memrd,
   output logic          mem_memwr,
   output logic          br_taken,
   output logic          exc_pending,
   input  logic          exc_ack
);
   typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
   typedef struct packed {
      logic [DW-1:0] result;
      logic [3:0]    flags;
      logic [DW-1:0] store;
      logic [RW-1:0] rd;
      logic          regwr;
      logic          memrd;
      logic          memwr;
      logic          taken;
      logic          ovf;
   } entry_t;

   state_t state;
   entry_t main_q, skid_q, in_e;
   logic acc, xfer, ovf, taken;

   assign acc   = ex_valid & ex_ready;
   assign xfer  = mem_valid & mem_ready;
   assign ovf   = ctl_trap & alu_v;
   assign taken = ctl_branch & (alu_zero ^ ctl_bne);

   // Branches never write back or touch memory; trapped ops keep data but lose their side effects.
   always_comb begin
      in_e.result = alu_ri;
      in_e.flags  = {alu_co, alu_zero, alu_v, alu_set};
      in_e.store  = rt_data;
      in_e.rd     = rd_addr;
      in_e.regwr  = ctl_regwr & ~ctl_branch & ~ovf;
      in_e.memrd  = ctl_memrd & ~ctl_branch;
      in_e.memwr  = ctl_memwr & ~ctl_branch & ~ovf;
      in_e.taken  = taken;
      in_e.ovf    = ovf;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= EMPTY;
         main_q      <= '0;
         skid_q      <= '0;
         ex_ready    <= 1'b1;
         mem_valid   <= 1'b0;
         exc_pending <= 1'b0;
      end else begin
         // A fresh overflow leaving the stage wins over a simultaneous ack.
         exc_pending <= (xfer & main_q.ovf & ~flush) | (exc_pending & ~exc_ack);
         if (flush) begin
            state     <= EMPTY;
            mem_valid <= 1'b0;
            ex_ready  <= 1'b1;
         end else begin
            case (state)
               EMPTY: if (acc) begin
                  main_q    <= in_e;
                  state     <= ONE;
                  mem_valid <= 1'b1;
               end
               ONE: begin
                  if (acc && !xfer) begin
                     skid_q   <= in_e;
                     state    <= TWO;
                     ex_ready <= 1'b0;
                  end else if (acc && xfer) begin
                     main_q <= in_e;
                  end else if (xfer) begin
                     state     <= EMPTY;
                     mem_valid <= 1'b0;
                  end
               end
               TWO: if (xfer) begin
                  main_q   <= skid_q;
                  state    <= ONE;
                  ex_ready <= 1'b1;
               end
               default: begin
                  state     <= EMPTY;
                  mem_valid <= 1'b0;
                  ex_ready  <= 1'b1;
               end
            endcase
         end
      end
   end

   assign mem_result = main_q.result;
   assign mem_flags  = main_q.flags;
   assign mem_store  = main_q.store;
   assign mem_rd     = main_q.rd;
   assign mem_regwr  = main_q.regwr;
   assign mem_memrd  = main_q.memrd;
   assign mem_memwr  = main_q.memwr;
   assign br_taken   = main_q.taken;
endmodule

// File: tb/tb_ex_mem_stage.sv
// tb_ex_mem_stage: directed and random checks of ex_mem_stage against an occupancy-queue model.
module tb_ex_mem_stage;
   logic        clk = 1'b0, rst_n = 1'b0;
   logic        ex_valid = 0, ex_ready;
   logic [31:0] alu_ri = 0, rt_data = 0;
   logic        alu_co = 0, alu_zero = 0, alu_v = 0, alu_set = 0;
   logic [4:0]  rd_addr = 0;
   logic        ctl_regwr = 0, ctl_memrd = 0, ctl_memwr = 0, ctl_branch = 0, ctl_bne = 0, ctl_trap = 0;
   logic        flush = 0, mem_valid, mem_ready = 0, exc_ack = 0;
   logic [31:0] mem_result, mem_store;
   logic [3:0]  mem_flags;
   logic [4:0]  mem_rd;
   logic        mem_regwr, mem_memrd, mem_memwr, br_taken, exc_pending;

   ex_mem_stage dut (
      .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_ready(ex_ready),
      .alu_ri(alu_ri), .alu_co(alu_co), .alu_zero(alu_zero), .alu_v(alu_v), .alu_set(alu_set),
      .rt_data(rt_data), .rd_addr(rd_addr), .ctl_regwr(ctl_regwr), .ctl_memrd(ctl_memrd),
      .ctl_memwr(ctl_memwr), .ctl_branch(ctl_branch), .ctl_bne(ctl_bne), .ctl_trap(ctl_trap),
      .flush(flush), .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_result(mem_result),
      .mem_flags(mem_flags), .mem_store(mem_store), .mem_rd(mem_rd), .mem_regwr(mem_regwr),
      .mem_memrd(mem_memrd), .mem_memwr(mem_memwr), .br_taken(br_taken),
      .exc_pending(exc_pending), .exc_ack(exc_ack)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] res;
      logic [3:0]  fl;
      logic [31:0] st;
      logic [4:0]  rd;
      logic        rw, mr, mw, tk, ovf;
   } exp_t;

   exp_t q[$];
   logic exc_m = 1'b0;
   int n_checks = 0, n_fail = 0, n_in = 0, dut_out = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t capture();
      exp_t e;
      e.res = alu_ri;
      e.fl  = {alu_co, alu_zero, alu_v, alu_set};
      e.st  = rt_data;
      e.rd  = rd_addr;
      e.ovf = ctl_trap && alu_v;
      e.tk  = ctl_branch && (alu_zero != ctl_bne);
      e.rw  = ctl_regwr && !ctl_branch && !e.ovf;
      e.mr  = ctl_memrd && !ctl_branch;
      e.mw  = ctl_memwr && !ctl_branch && !e.ovf;
      return e;
   endfunction

   task automatic chk_all();
      chk("mem_valid", mem_valid, q.size() > 0);
      chk("ex_ready", ex_ready, q.size() < 2);
      chk("exc_pending", exc_pending, exc_m);
      if (q.size() > 0) begin
         chk("mem_result", mem_result, q[0].res);
         chk("mem_flags", mem_flags, q[0].fl);
         chk("mem_store", mem_store, q[0].st);
         chk("mem_rd", mem_rd, q[0].rd);
         chk("mem_ctl", {mem_regwr, mem_memrd, mem_memwr}, {q[0].rw, q[0].mr, q[0].mw});
         chk("br_taken", br_taken, q[0].tk);
      end
   endtask

   // One clock: the model decides accept/transfer from its own occupancy, then compares.
   task automatic cyc();
      exp_t e;
      logic acc, xf, popped_ovf;
      acc = ex_valid && q.size() < 2;
      xf  = mem_ready && q.size() > 0;
      e = capture();
      if (mem_valid && mem_ready && !flush) dut_out++;
      @(posedge clk);
      if (flush) begin
         q.delete();
         exc_m = exc_m && !exc_ack;
      end else begin
         popped_ovf = 1'b0;
         if (xf) popped_ovf = q.pop_front().ovf;
         if (acc) begin
            q.push_back(e);
            n_in++;
         end
         exc_m = popped_ovf || (exc_m && !exc_ack);
      end
      #1;
      chk_all();
   endtask

   task automatic put(input logic v, input logic [31:0] ri, input logic [4:0] rd, input logic rw,
                      input logic br, input logic bne, input logic z, input logic trap, input logic ov);
      ex_valid = v; alu_ri = ri; rd_addr = rd; ctl_regwr = rw; ctl_branch = br; ctl_bne = bne;
      alu_zero = z; ctl_trap = trap; alu_v = ov; alu_co = 0; alu_set = 0;
      rt_data = ri ^ 32'hA5A5_0000; ctl_memrd = 0; ctl_memwr = rw;
   endtask

   initial begin
      #12;
      chk("rst_mem_valid", mem_valid, 1'b0);
      chk("rst_ex_ready", ex_ready, 1'b1);
      chk("rst_exc", exc_pending, 1'b0);
      chk("rst_data", {mem_result, mem_store, mem_flags, mem_rd}, '0);
      chk("rst_ctl", {mem_regwr, mem_memrd, mem_memwr, br_taken}, '0);
      rst_n = 1'b1;

      // single entry, one-cycle latency
      put(1, 32'h5, 5'd3, 1, 0, 0, 0, 0, 0); mem_ready = 1;
      cyc();
      chk("t1_valid", mem_valid, 1'b1);
      chk("t1_result", mem_result, 32'h5);
      chk("t1_rd", mem_rd, 5'd3);
      chk("t1_regwr", mem_regwr, 1'b1);
      chk("t1_ready", ex_ready, 1'b1);
      ex_valid = 0; cyc();

      // backpressure fills main and skid
      mem_ready = 0;
      put(1, 32'h11, 5'd1, 1, 0, 0, 0, 0, 0); cyc();
      put(1, 32'h22, 5'd2, 1, 0, 0, 0, 0, 0); cyc();
      chk("bp_ready_full", ex_ready, 1'b0);
      put(1, 32'h33, 5'd3, 1, 0, 0, 0, 0, 0); cyc();
      chk("bp_hold_a", mem_result, 32'h11);
      ex_valid = 0; mem_ready = 1; cyc();
      chk("bp_b_next", mem_result, 32'h22);
      chk("bp_ready_back", ex_ready, 1'b1);
      cyc();
      chk("bp_drained", mem_valid, 1'b0);

      // branch resolution
      put(1, 32'h0, 5'd4, 1, 1, 0, 1, 0, 0); cyc();
      chk("beq_taken", br_taken, 1'b1);
      chk("beq_regwr", mem_regwr, 1'b0);
      put(1, 32'h0, 5'd4, 1, 1, 1, 1, 0, 0); cyc();
      chk("bne_z1", br_taken, 1'b0);
      put(1, 32'h1, 5'd4, 1, 1, 1, 0, 0, 0); cyc();
      chk("bne_z0", br_taken, 1'b1);
      ex_valid = 0; cyc();

      // overflow trap
      mem_ready = 0;
      put(1, 32'h8000_0000, 5'd7, 1, 0, 0, 0, 1, 1); cyc();
      chk("ovf_regwr", mem_regwr, 1'b0);
      chk("ovf_flag_v", mem_flags[1], 1'b1);
      chk("ovf_not_yet", exc_pending, 1'b0);
      ex_valid = 0; mem_ready = 1; cyc();
      chk("ovf_set", exc_pending, 1'b1);
      cyc();
      chk("ovf_sticky", exc_pending, 1'b1);
      exc_ack = 1; cyc();
      chk("ovf_acked", exc_pending, 1'b0);
      exc_ack = 0;
      put(1, 32'h8000_0000, 5'd8, 1, 0, 0, 0, 1, 1); cyc();
      cyc();
      chk("ovf_x_set", exc_pending, 1'b1);
      ex_valid = 0; exc_ack = 1; cyc();
      chk("ovf_ack_vs_set", exc_pending, 1'b1);
      cyc();
      chk("ovf_clear2", exc_pending, 1'b0);
      exc_ack = 0;

      // flush in TWO suppresses accept, transfer and exception setting
      mem_ready = 0;
      put(1, 32'h8000_0000, 5'd9, 1, 0, 0, 0, 1, 1); cyc(); cyc();
      chk("fl_two", ex_ready, 1'b0);
      mem_ready = 1; flush = 1; cyc();
      chk("fl_valid", mem_valid, 1'b0);
      chk("fl_ready", ex_ready, 1'b1);
      chk("fl_no_exc", exc_pending, 1'b0);
      flush = 0; ex_valid = 0; cyc();
      chk("fl_no_capture", mem_valid, 1'b0);
      put(1, 32'h8000_0000, 5'd9, 1, 0, 0, 0, 1, 1); cyc();
      ex_valid = 0; cyc();
      flush = 1; cyc();
      chk("fl_keeps_exc", exc_pending, 1'b1);
      flush = 0; exc_ack = 1; cyc(); exc_ack = 0;

      // asynchronous reset mid-operation
      mem_ready = 0;
      put(1, 32'h77, 5'd5, 1, 0, 0, 0, 0, 0); cyc();
      ex_valid = 0;
      #2 rst_n = 0;
      #1;
      chk("arst_valid", mem_valid, 1'b0);
      chk("arst_ready", ex_ready, 1'b1);
      q.delete(); exc_m = 0;
      rst_n = 1;

      // random streaming
      n_in = 0; dut_out = 0;
      for (int c = 0; c < 3000 && n_in < 100; c++) begin
         ex_valid = ($urandom_range(0, 3) != 0) && (n_in + q.size() < 100 || q.size() == 0) && n_in < 100;
         mem_ready = $urandom_range(0, 2) != 0;
         alu_ri = $urandom(); rt_data = $urandom(); rd_addr = 5'($urandom());
         {alu_co, alu_zero, alu_v, alu_set} = 4'($urandom());
         {ctl_regwr, ctl_memrd, ctl_memwr} = 3'($urandom());
         ctl_branch = $urandom_range(0, 3) == 0; ctl_bne = 1'($urandom());
         ctl_trap = 1'($urandom()); exc_ack = $urandom_range(0, 3) == 0;
         cyc();
      end
      ex_valid = 0; mem_ready = 1;
      for (int c = 0; c < 10 && q.size() > 0; c++) cyc();
      cyc();
      chk("stream_in", n_in, 100);
      chk("stream_out", dut_out, n_in);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
